// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction fields into 16-bit microRISC words and writes them to IMEM at an auto-incrementing address.
// Optional build macro: ENC_FIELD_CHECK_EN rejects beats whose type and opcode disagree and drives err.
// Ports: clk, rst (sync, active high); start/base_addr open a session; in_valid/in_ready/in_* fields/in_last are the beat stream;
// imem_we/imem_addr/imem_wdata form the IMEM write port; busy, done, overflow, count and err report session status.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_type,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_funct,
  input  logic [5:0]        in_imm,
  input  logic [11:0]       in_jtarget,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count,
  output logic              err
);
  // microRISC field positions
  localparam int OPCODE_POS = 12;
  localparam int RS_POS     = 9;
  localparam int RT_POS     = 6;
  localparam int RD_POS     = 3;
  localparam int FUNC_POS   = 0;
  localparam int IMM_POS    = 0;
  localparam int J_ADDR_POS = 0;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [15:0]       r_word;
  logic [15:0]       i_word;
  logic [15:0]       j_word;
  logic [15:0]       packed_word;
  logic              legal;
  logic              acc;
  logic              wr;
  logic              last_addr;
  logic              open;
  always_comb begin
    r_word = (16'(in_opcode) << OPCODE_POS) | (16'(in_rs) << RS_POS) | (16'(in_rt) << RT_POS)
           | (16'(in_rd) << RD_POS) | (16'(in_funct) << FUNC_POS);
    i_word = (16'(in_opcode) << OPCODE_POS) | (16'(in_rs) << RS_POS) | (16'(in_rt) << RT_POS)
           | (16'(in_imm) << IMM_POS);
    j_word = (16'(in_opcode) << OPCODE_POS) | (16'(in_jtarget) << J_ADDR_POS);
    // type 3 packs as R
    packed_word = in_type == 2'd1 ? i_word : in_type == 2'd2 ? j_word : r_word;
  end
`ifdef ENC_FIELD_CHECK_EN
  localparam logic [3:0] OP_R_TYPE = 4'h0;
  localparam logic [3:0] OP_J      = 4'hD;
  localparam logic [3:0] OP_JAL    = 4'hE;
  localparam logic [3:0] OP_JR     = 4'hF;
  logic is_jump;
  assign is_jump = in_opcode == OP_J || in_opcode == OP_JAL || in_opcode == OP_JR;
  assign legal = in_type == 2'd0 ? in_opcode == OP_R_TYPE :
                 in_type == 2'd1 ? !(in_opcode == OP_R_TYPE || is_jump) :
                 in_type == 2'd2 ? is_jump : 1'b0;
  always_ff @(posedge clk)
    if (rst) err <= 1'b0;
    else if (open) err <= 1'b0;
    else if (acc && !legal) err <= 1'b1;
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif
  assign open      = state == S_IDLE && start;
  assign acc       = state == S_LOAD && in_valid;
  assign wr        = acc && legal;
  assign last_addr = addr_cnt == ADDR_W'(MEM_DEPTH - 1);
  assign in_ready  = state == S_LOAD;
  assign busy      = state == S_LOAD || state == S_FLUSH;
  assign done      = state == S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= wr;
      if (wr) begin
        imem_addr  <= addr_cnt;
        imem_wdata <= packed_word;
        // the session ends at the last legal address, so the counter is held there rather than wrapped
        addr_cnt   <= last_addr ? addr_cnt : addr_cnt + ADDR_W'(1);
        count      <= count + (ADDR_W + 1)'(1);
      end
      case (state)
        S_IDLE:
          if (start) begin
            state    <= S_LOAD;
            addr_cnt <= base_addr;
            count    <= '0;
            overflow <= 1'b0;
          end
        S_LOAD:
          if (acc && in_last) state <= S_FLUSH;
          else if (wr && last_addr) begin
            state    <= S_FLUSH;
            overflow <= 1'b1;
          end
        S_FLUSH: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
